// File: rtl/idma_tilelink_write_splitter_pkg.sv
// rtl/idma_tilelink_write_splitter_pkg.sv - shared iDMA TileLink types and constants
// Struct layouts describe the default configuration; the top packs its flat ports in the same field order.
package idma_tilelink_write_splitter_pkg;

  localparam int unsigned DefAddrWidth   = 32;
  localparam int unsigned DefStrbWidth   = 16;
  localparam int unsigned DefSourceWidth = 4;
  localparam int unsigned DefOffsetWidth = $clog2(DefStrbWidth);

  localparam int unsigned SizeWidth = 4;
  localparam int unsigned OpcodeWidth = 3;
  localparam int unsigned ParamWidth = 3;

  localparam logic [OpcodeWidth-1:0] TlPutPartialData = 3'd1;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefAddrWidth-1:0] len;
  } req_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   address;
    logic [SizeWidth-1:0]      size;
    logic [DefSourceWidth-1:0] source;
    logic [OpcodeWidth-1:0]    opcode;
    logic [ParamWidth-1:0]     param;
    logic                      last;
  } meta_t;

  typedef struct packed {
    logic [DefOffsetWidth-1:0] offset;
    logic [DefOffsetWidth-1:0] tailer;
    logic                      is_single;
  } w_dp_req_t;

endpackage

// File: rtl/idma_tilelink_write_splitter_chunk.sv
// rtl/idma_tilelink_write_splitter_chunk.sv - combinational chunk sizing for one TileLink burst
// Picks the largest power-of-two beat count bounded by remaining data, base alignment and max burst.
module idma_tilelink_chunk_calc
  import idma_tilelink_write_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned StrbWidth   = 16,
  parameter int unsigned BurstLength = 64
) (
  input  logic [AddrWidth-1:0] cursor_i,
  input  logic [AddrWidth-1:0] end_i,
  output logic [AddrWidth-1:0] base_o,
  output logic [AddrWidth-1:0] next_o,
  output logic [SizeWidth-1:0] size_o,
  output logic                 last_o,
  output logic                 is_single_o
);

  localparam int unsigned OffW        = $clog2(StrbWidth);
  localparam int          MaxBeatsLog = $clog2(BurstLength / StrbWidth);

  logic [AddrWidth-1:0] strb_mask;
  logic [AddrWidth-1:0] beats;
  logic [AddrWidth-1:0] beat_idx;
  logic [SizeWidth-1:0] beats_log;

  assign strb_mask = AddrWidth'(StrbWidth - 1);
  assign base_o    = cursor_i & ~strb_mask;
  assign beats     = (end_i - base_o + strb_mask) >> OffW;
  assign beat_idx  = base_o >> OffW;

  // Both limits are monotone in i, so the last passing exponent is the answer.
  always_comb begin
    beats_log = '0;
    for (int i = 1; i <= MaxBeatsLog; i++) begin
      if ((beats >= (AddrWidth'(1) << i)) &&
          ((beat_idx & ((AddrWidth'(1) << i) - AddrWidth'(1))) == '0)) begin
        beats_log = SizeWidth'(i);
      end
    end
  end

  assign size_o      = beats_log + SizeWidth'(OffW);
  assign next_o      = base_o + (AddrWidth'(1) << size_o);
  assign last_o      = (next_o >= end_i);
  assign is_single_o = (beats_log == '0);

endmodule

// File: rtl/idma_tilelink_write_splitter.sv
// rtl/idma_tilelink_write_splitter.sv - splits byte-granular writes into TileLink PutPartialData bursts
// Each burst is forked to the A-channel header and the write-stage beat-mask descriptor.
module idma_tilelink_write_splitter
  import idma_tilelink_write_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned StrbWidth   = 16,
  parameter int unsigned BurstLength = 64,
  parameter int unsigned SourceWidth = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [2*AddrWidth-1:0]                         req_i,
  input  logic                                           req_valid_i,
  output logic                                           req_ready_o,
  output logic [AddrWidth+SizeWidth+SourceWidth+6:0]     meta_o,
  output logic                                           meta_valid_o,
  input  logic                                           meta_ready_i,
  output logic [2*$clog2(StrbWidth):0]                   w_dp_req_o,
  output logic                                           w_dp_valid_o,
  input  logic                                           w_dp_ready_i
);

  localparam int unsigned OffW = $clog2(StrbWidth);

  split_state_e          state_q, state_d;
  logic [AddrWidth-1:0]  cursor_q, cursor_d;
  logic [AddrWidth-1:0]  end_q, end_d;
  logic                  first_q, first_d;
  logic [SourceWidth-1:0] source_q, source_d;
  logic                  meta_done_q, meta_done_d;
  logic                  wdp_done_q, wdp_done_d;

  logic [AddrWidth-1:0]  req_addr, req_len;
  logic [AddrWidth-1:0]  chunk_base, chunk_next;
  logic [SizeWidth-1:0]  chunk_size;
  logic                  chunk_last, chunk_single;
  logic                  meta_fin, wdp_fin;
  logic [OffW-1:0]       offset, tailer;

  assign req_addr = req_i[2*AddrWidth-1:AddrWidth];
  assign req_len  = req_i[AddrWidth-1:0];

  idma_tilelink_chunk_calc #(
    .AddrWidth  (AddrWidth),
    .StrbWidth  (StrbWidth),
    .BurstLength(BurstLength)
  ) i_chunk_calc (
    .cursor_i   (cursor_q),
    .end_i      (end_q),
    .base_o     (chunk_base),
    .next_o     (chunk_next),
    .size_o     (chunk_size),
    .last_o     (chunk_last),
    .is_single_o(chunk_single)
  );

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    end_d        = end_q;
    first_d      = first_q;
    source_d     = source_q;
    meta_done_d  = meta_done_q;
    wdp_done_d   = wdp_done_q;
    req_ready_o  = 1'b0;
    meta_valid_o = 1'b0;
    w_dp_valid_o = 1'b0;
    meta_fin     = 1'b0;
    wdp_fin      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        // Zero-length requests are consumed here and never reach SPLIT.
        if (req_valid_i && (req_len != '0)) begin
          cursor_d = req_addr;
          end_d    = req_addr + req_len;
          first_d  = 1'b1;
          state_d  = SPLIT;
        end
      end
      SPLIT: begin
        meta_valid_o = !meta_done_q;
        w_dp_valid_o = !wdp_done_q;
        meta_fin     = meta_done_q | meta_ready_i;
        wdp_fin      = wdp_done_q | w_dp_ready_i;
        if (meta_fin && wdp_fin) begin
          cursor_d    = chunk_next;
          first_d     = 1'b0;
          source_d    = source_q + SourceWidth'(1);
          meta_done_d = 1'b0;
          wdp_done_d  = 1'b0;
          if (chunk_last) begin
            state_d = IDLE;
          end
        end else begin
          meta_done_d = meta_fin;
          wdp_done_d  = wdp_fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      end_q       <= '0;
      first_q     <= 1'b0;
      source_q    <= '0;
      meta_done_q <= 1'b0;
      wdp_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      end_q       <= end_d;
      first_q     <= first_d;
      source_q    <= source_d;
      meta_done_q <= meta_done_d;
      wdp_done_q  <= wdp_done_d;
    end
  end

  assign offset = first_q ? cursor_q[OffW-1:0] : '0;
  assign tailer = chunk_last ? end_q[OffW-1:0] : '0;

  assign meta_o     = {chunk_base, chunk_size, source_q, TlPutPartialData,
                       {ParamWidth{1'b0}}, chunk_last};
  assign w_dp_req_o = {offset, tailer, chunk_single};

endmodule

// File: doc/idma_tilelink_write_splitter.md
IDMA_TILELINK_WRITE_SPLITTER -- requirements
Module: idma_tilelink_write_splitter

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, meaning byte-address and length width.
REQ-002 SHALL have parameter StrbWidth, default 16, meaning bytes per bus beat (power of two).
REQ-003 SHALL have parameter BurstLength, default 64, meaning max TileLink burst in bytes (power of two, >= StrbWidth).
REQ-004 SHALL have parameter SourceWidth, default 4, meaning TileLink source-ID width.
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-006 SHALL have port rst_ni, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port req_i, input, {addr, len} (2*AddrWidth), meaning byte-granular write transfer.
REQ-008 SHALL have ports req_valid_i (input, 1) and req_ready_o (output, 1), meaning the transfer handshake.
REQ-009 SHALL have port meta_o, output, {address, size, source, opcode, param, last}, meaning the A-channel header of one burst.
REQ-010 SHALL have ports meta_valid_o (output, 1) and meta_ready_i (input, 1), meaning the meta handshake.
REQ-011 SHALL have port w_dp_req_o, output, {offset, tailer, is_single}, meaning the beat-mask descriptor for the write stage.
REQ-012 SHALL have ports w_dp_valid_o (output, 1) and w_dp_ready_i (input, 1), meaning the datapath handshake.

Function
REQ-013 SHALL implement FSM {IDLE, SPLIT}; req_ready_o=1 only in IDLE.
REQ-014 In IDLE, SHALL on req_valid_i with len!=0 latch cursor=addr, end=addr+len, first=1, and enter SPLIT.
REQ-015 In IDLE, SHALL accept len==0 and drop it, producing no output and staying in IDLE.
REQ-016 In SPLIT, SHALL compute each chunk combinationally from registers: base=cursor aligned down to StrbWidth; B=ceil((end-base)/StrbWidth).
REQ-017 SHALL set chunk beats N = min(largest power of two <= B, natural alignment of base/StrbWidth, BurstLength/StrbWidth).
REQ-018 SHALL drive meta address=base, size=log2(N*StrbWidth), opcode=PutPartialData (1), param=0, and last=(base+N*StrbWidth >= end).
REQ-019 SHALL drive offset=cursor mod StrbWidth when first=1, else 0.
REQ-020 SHALL drive tailer=end mod StrbWidth when last=1, else 0.
REQ-021 SHALL drive is_single=(N==1).
REQ-022 SHALL assert both valids in SPLIT using a fork: each output's valid drops once that output handshakes; payloads stay stable until both have handshaked.
REQ-023 SHALL advance the chunk only when both outputs have handshaked (same or different cycles): cursor=base+N*StrbWidth, first=0, source+=1 (wrapping mod 2^SourceWidth).
REQ-024 SHALL return to IDLE on completion of the last chunk; the next req is accepted at the earliest one cycle later.
REQ-025 SHALL add no bubble between chunks; back-to-back chunks are presented in consecutive cycles when both readys are high.
REQ-026 SHALL compute address/end arithmetic at AddrWidth, with wrap beyond 2^AddrWidth undefined and excluded from verification.

Reset
REQ-027 On reset, SHALL set state=IDLE, fork flags cleared, source=0, cursor/end/first=0, so that req_ready_o=1 and meta_valid_o=w_dp_valid_o=0.
REQ-028 Reset mid-SPLIT SHALL abandon the pending chunk immediately (asynchronous); no partial state survives.

Structure
REQ-029 SHALL place the req, meta and w_dp_req typedefs plus the opcode constant and size-width localparam in the shared iDMA TileLink package.
REQ-030 SHALL isolate the chunk-size computation (REQ-016..017) in sub-module idma_tilelink_chunk_calc (purely combinational); the FSM and fork live in the top.

Verification (StrbWidth=16, BurstLength=64)
REQ-031 Aligned burst: addr 0x100, len 64 -> one chunk: address 0x100, size 6, offset 0, tailer 0, is_single 0, last 1.
REQ-032 Unaligned: addr 0x104, len 25 -> one chunk: address 0x100, size 5, offset 4, tailer 13, is_single 0, last 1.
REQ-033 Split: addr 0x130, len 0x60 -> three chunks: (0x130, size 4, single), (0x140, size 6), (0x180, size 4, single, last); sources 0, 1, 2.
REQ-034 Skewed backpressure: meta_ready_i=1, w_dp_ready_i=0 for 3 cycles -> meta handshakes once, meta_valid_o drops, w_dp_o stays stable, and no advance occurs until w_dp_ready_i=1.
REQ-035 Zero length: len 0 -> accepted, no valids ever asserted, req_ready_o stays 1.
REQ-036 Reset asserted during the second chunk of REQ-033 -> valids drop asynchronously, state is IDLE, and the next transfer starts with source 0.
